// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, cascade terminal count and sticky wrap flag.
// Define UPDOWN_SAT_EN to make the counter saturate at its boundaries instead of wrapping.
module updown_mod_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             CLR_WRAP,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             wrap_r;
    logic             wrap_nxt_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             boundary_s;

    // Out-of-range load values collapse onto the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        if (d > MAX_VAL) begin
            r = MAX_VAL;
        end else begin
            r = d;
        end
        return r;
    endfunction

    assign at_max_s   = (cnt_r == MAX_VAL);
    assign at_zero_s  = (cnt_r == ZERO_VAL);
    // A load in the same cycle masks the boundary, so TC and boundary share one term.
    assign boundary_s = ~LOAD & EN & (UP ? at_max_s : at_zero_s);

    // Next-state selection: load, then enabled count, then hold.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        wrap_nxt_s = wrap_r;
        if (LOAD) begin
            cnt_nxt_s = clamp_load(DIN);
            if (CLR_WRAP) begin
                wrap_nxt_s = 1'b0;
            end else begin
                wrap_nxt_s = wrap_r;
            end
        end else if (boundary_s) begin
            wrap_nxt_s = 1'b1;
`ifdef UPDOWN_SAT_EN
            cnt_nxt_s  = cnt_r;
`else
            cnt_nxt_s  = UP ? ZERO_VAL : MAX_VAL;
`endif
        end else begin
            if (EN) begin
                if (UP) begin
                    cnt_nxt_s = cnt_r + ONE_VAL;
                end else begin
                    cnt_nxt_s = cnt_r - ONE_VAL;
                end
            end else begin
                cnt_nxt_s = cnt_r;
            end
            if (CLR_WRAP) begin
                wrap_nxt_s = 1'b0;
            end else begin
                wrap_nxt_s = wrap_r;
            end
        end
    end

    // State registers with synchronous reset overriding every other control.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r  <= ZERO_VAL;
            wrap_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign CNT  = cnt_r;
    assign WRAP = wrap_r;
    assign TC   = boundary_s;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULO=10): directed cases plus
// randomized stimulus compared every cycle against an arithmetic reference model.
module tb_updown_mod_counter;

    localparam int W = 4;
    localparam int M = 10;
`ifdef UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         EN = 1'b0;
    logic         UP = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         CLR_WRAP = 1'b0;
    logic [W-1:0] CNT;
    logic         TC;
    logic         WRAP;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;
    int m_wrap = 0;
    bit m_valid = 1'b0;

    updown_mod_counter #(.WIDTH(W), .MODULO(M)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
        .CLR_WRAP(CLR_WRAP), .CNT(CNT), .TC(TC), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_tc();
        if (LOAD || !EN) return 0;
        if (UP) return (m_cnt == M - 1) ? 1 : 0;
        return (m_cnt == 0) ? 1 : 0;
    endfunction

    task automatic model_step();
        int bnd;
        if (RST) begin
            m_cnt = 0;
            m_wrap = 0;
            m_valid = 1'b1;
        end else if (LOAD) begin
            m_cnt = (int'(DIN) >= M) ? M - 1 : int'(DIN);
            if (CLR_WRAP) m_wrap = 0;
        end else begin
            bnd = model_tc();
            if (EN) begin
                if (bnd == 1 && SAT) m_cnt = m_cnt;
                else if (UP) m_cnt = (m_cnt + 1) % M;
                else m_cnt = (m_cnt + M - 1) % M;
            end
            if (bnd == 1) m_wrap = 1;
            else if (CLR_WRAP) m_wrap = 0;
        end
    endtask

    task automatic drive(input bit rst, input bit load, input bit en, input bit up,
                         input bit clr, input int din);
        RST = rst; LOAD = load; EN = en; UP = up; CLR_WRAP = clr;
        DIN = din[W-1:0];
        #1;
    endtask

    // One clock: compare TC before the edge, advance the model, compare state after it.
    task automatic tick();
        if (m_valid) chk("tc_model", int'(TC), model_tc());
        model_step();
        @(posedge CLK);
        #1;
        chk("cnt_model", int'(CNT), m_cnt);
        chk("wrap_model", int'(WRAP), m_wrap);
    endtask

    initial begin
        int exp_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        @(posedge CLK);
        #1;
        // Reset state
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("reset_cnt", int'(CNT), 0);
        chk("reset_wrap", int'(WRAP), 0);

        // Up count through the top of the range
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            chk("up_tc", int'(TC), (i == 9) ? 1 : 0);
            if (SAT && i == 9) begin
                tick();
                chk("sat_up_cnt", int'(CNT), 9);
            end else begin
                tick();
                chk("up_cnt", int'(CNT), exp_seq[i]);
            end
            chk("up_wrap", int'(WRAP), (i == 9) ? 1 : 0);
        end
        if (SAT) begin
            for (int i = 0; i < 3; i++) begin
                drive(0, 0, 1, 1, 0, 0);
                chk("sat_hold_tc", int'(TC), 1);
                tick();
                chk("sat_hold_cnt", int'(CNT), 9);
                chk("sat_hold_wrap", int'(WRAP), 1);
            end
        end

        // Down count from reset
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("down_tc", int'(TC), 1);
        tick();
        chk("down_cnt", int'(CNT), SAT ? 0 : 9);
        chk("down_wrap", int'(WRAP), 1);

        // Load clamp with EN active; WRAP must be untouched
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 1, 0, 13);
        chk("load_tc", int'(TC), 0);
        tick();
        chk("load_cnt", int'(CNT), 9);
        chk("load_wrap", int'(WRAP), 0);
        drive(0, 1, 1, 1, 0, 4);
        chk("load_at_max_tc", int'(TC), 0);
        tick();
        chk("load_at_max_cnt", int'(CNT), 4);
        chk("load_at_max_wrap", int'(WRAP), 0);

        // Set wins over clear, then clear with EN low
        drive(0, 1, 0, 0, 0, 9);
        tick();
        drive(0, 0, 1, 1, 1, 0);
        tick();
        chk("setclr_wrap", int'(WRAP), 1);
        chk("setclr_cnt", int'(CNT), SAT ? 9 : 0);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("clr_wrap", int'(WRAP), 0);

        // Reset mid-count beats a simultaneous load
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        chk("pre_rst_wrap", int'(WRAP), 1);
        drive(0, 1, 0, 0, 0, 5);
        tick();
        drive(0, 0, 1, 1, 0, 0);
        tick();
        chk("pre_rst_cnt", int'(CNT), 6);
        drive(1, 1, 1, 1, 0, 3);
        tick();
        chk("midrst_cnt", int'(CNT), 0);
        chk("midrst_wrap", int'(WRAP), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 The block SHALL have parameter MODULO, default 16, count range 0..MODULO-1 (2 <= MODULO <= 2^WIDTH).
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock, sole clock.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port EN  input  1  count enable.
REQ-006 The block SHALL have port UP  input  1  direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port LOAD  input  1  synchronous parallel load strobe.
REQ-008 The block SHALL have port DIN  input  WIDTH  load value.
REQ-009 The block SHALL have port CLR_WRAP  input  1  clears the WRAP sticky flag.
REQ-010 The block SHALL have port CNT  output  WIDTH  registered count value.
REQ-011 The block SHALL have port TC  output  1  terminal count, combinational, cascade carry/borrow.
REQ-012 The block SHALL have port WRAP  output  1  registered sticky wrap or saturation flag.

Function
REQ-013 Per-edge priority SHALL be RST, then LOAD, then EN, then hold.
REQ-014 LOAD=1 SHALL set CNT to DIN next edge, independent of EN and UP; DIN >= MODULO SHALL load MODULO-1.
REQ-015 EN=1, UP=1, CNT<MODULO-1 SHALL increment CNT by 1 next edge.
REQ-016 EN=1, UP=0, CNT>0 SHALL decrement CNT by 1 next edge.
REQ-017 EN=1, UP=1, CNT=MODULO-1 SHALL be an up-boundary event; EN=1, UP=0, CNT=0 SHALL be a down-boundary event.
REQ-018 At a boundary event without the macro, CNT SHALL wrap to 0 (up) or MODULO-1 (down).
REQ-019 A boundary event SHALL set WRAP=1 on the same edge CNT updates.
REQ-020 TC SHALL equal EN AND ((UP AND CNT=MODULO-1) OR (NOT UP AND CNT=0)), with zero latency.
REQ-021 LOAD=1 SHALL force TC=0 and SHALL suppress any boundary event in that cycle.
REQ-022 CLR_WRAP=1 SHALL clear WRAP next edge unless a boundary event occurs in the same cycle; the set wins.
REQ-023 A direction change SHALL take effect on the next enabled edge with no dead cycle.
REQ-024 EN=0 and LOAD=0 SHALL hold CNT and WRAP unchanged. CLR_WRAP SHALL still clear WRAP.
REQ-025 For MODULO = 2^WIDTH, wrap SHALL be the natural modulo-2^WIDTH roll with identical TC and WRAP behaviour.

Reset
REQ-026 RST=1 at a rising edge SHALL set CNT=0 and WRAP=0, overriding LOAD, EN and CLR_WRAP.
REQ-027 Asserting RST mid-count SHALL discard the count in progress, with no partial update.
REQ-028 TC SHALL evaluate from the post-reset CNT=0: TC=1 when EN=1 and UP=0.

Configuration
REQ-029 Macro UPDOWN_SAT_EN SHALL select saturation. When defined, boundary events hold CNT at MODULO-1 (up) or 0 (down) instead of wrapping. WRAP is still set, and TC behaviour is unchanged.
REQ-030 When UPDOWN_SAT_EN is undefined, the block SHALL wrap per REQ-018. The port list SHALL be identical in both builds.

Verification
REQ-031 The bench SHALL cover up-count wrap. Stimulus: WIDTH=4, MODULO=10, RST 1 cycle, then EN=1, UP=1 for 10 edges. Required: CNT 1..9 then 0; TC=1 only while CNT=9; WRAP=1 after the 10th edge.
REQ-032 The bench SHALL cover down-count from reset. Stimulus: MODULO=10, UP=0, EN=1 after reset. Required: TC=1 at CNT=0; next edge CNT=9 and WRAP=1.
REQ-033 The bench SHALL cover load clamping and priority. Stimulus: LOAD=1, DIN=13, EN=1, MODULO=10. Required: CNT=9 next edge, TC=0 during the load cycle, WRAP unchanged.
REQ-034 The bench SHALL cover reset mid-count. Stimulus: counting at CNT=6, RST=1 with LOAD=1 and DIN=3. Required: CNT=0 and WRAP=0 next edge.
REQ-035 The bench SHALL cover set-versus-clear on WRAP. Stimulus: CNT=9, UP=1, EN=1, CLR_WRAP=1. Required: WRAP=1 after the edge; next edge, with EN=0 and CLR_WRAP=1, WRAP=0.
REQ-036 The bench SHALL cover the UPDOWN_SAT_EN build. Stimulus: CNT=9, UP=1, EN=1 for 3 edges. Required: CNT stays 9, WRAP=1, TC=1 throughout.
